irq_controller: RTL and testbench

- Arbitrates seven interrupt requesters onto the 68000 IPL2..0 lines and answers the CPU interrupt-acknowledge (IACK) cycle with AVEC.
- Sits beside BusControl in the glue FPGA and replaces the constant IPL/AVEC ties in Main.
- Provides per-source edge or level sensing, a bus-writable enable mask, and a small IACK handshake state machine.

---
 rtl/irq_controller.sv | 132 +++++++++++++
 tb/tb_irq_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - 68000 IPL arbiter with autovectored IACK handshake.
// Define IRQ_CONTROLLER_SPURIOUS_BERR_EN to answer spurious IACKs with BERR instead of AVEC.
module irq_controller #(
  parameter logic [6:0] EDGE_MASK  = 7'b1000000,
  parameter logic [6:0] MASK_RESET = 7'b1000000
) (
  input  logic        CPUCLK_IN,
  input  logic        RESET_n_IN,
  input  logic [6:0]  IRQ_IN,
  input  logic        AS_IN,
  input  logic [2:0]  FC_IN,
  input  logic [23:0] ADDR_IN,
  input  logic        MASK_WR_IN,
  input  logic [6:0]  MASK_DATA_IN,
  output logic [2:0]  IPL,
  output logic        AVEC,
  output logic        BERR,
  output logic [6:0]  PENDING
);

  typedef enum logic [1:0] {IDLE, ACK, SPUR} state_e;

  state_e      state_q;
  logic [6:0]  sync1_q, sync2_q, sync3_q;
  logic [6:0]  pend_q, pend_d;
  logic [6:0]  mask_q;
  logic [2:0]  ipl_q;
  logic        avec_q;
  logic [2:0]  lvl;
  logic        iack;
  logic        hit;
  logic        accept;
  logic [7:0]  pend_ext;
  logic [7:0]  sel_ext;
  logic [6:0]  clr;
  logic [6:0]  rise;
  logic [6:0]  active;
  logic        unused_ok;

  function automatic logic [2:0] prio_enc(input logic [6:0] v);
    prio_enc = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (v[i]) prio_enc = 3'(i + 1);
    end
  endfunction

  assign lvl      = ADDR_IN[3:1];
  assign iack     = AS_IN && (FC_IN == 3'b111) && (ADDR_IN[19:16] == 4'b1111) && (lvl != 3'd0);
  assign pend_ext = {pend_q, 1'b0};
  assign hit      = pend_ext[lvl];
  assign accept   = (state_q == IDLE) && iack && hit;
  assign sel_ext  = 8'd1 << lvl;
  assign clr      = accept ? sel_ext[7:1] : 7'd0;
  assign rise     = sync2_q & ~sync3_q;
  assign active   = pend_q & mask_q;
  assign unused_ok = ^{ADDR_IN[23:20], ADDR_IN[15:4], ADDR_IN[0], sel_ext[0]};

  // Edge bits: a fresh rise beats a simultaneous acknowledge clear.
  always_comb begin
    pend_d = (EDGE_MASK & ((pend_q & ~clr) | rise)) | (~EDGE_MASK & sync2_q);
  end

  always_ff @(posedge CPUCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      sync1_q <= 7'd0;
      sync2_q <= 7'd0;
      sync3_q <= 7'd0;
      pend_q  <= 7'd0;
      mask_q  <= MASK_RESET | 7'b1000000;
    end else begin
      sync1_q <= IRQ_IN;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q & EDGE_MASK;
      pend_q  <= pend_d;
      if (MASK_WR_IN) mask_q <= MASK_DATA_IN | 7'b1000000;
    end
  end

`ifdef IRQ_CONTROLLER_SPURIOUS_BERR_EN
  logic berr_q;
  assign BERR = berr_q;
`else
  assign BERR = 1'b0;
`endif

  // IPL only tracks the active vector in IDLE with no IACK in flight.
  always_ff @(posedge CPUCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      state_q <= IDLE;
      avec_q  <= 1'b0;
      ipl_q   <= 3'd0;
`ifdef IRQ_CONTROLLER_SPURIOUS_BERR_EN
      berr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (iack) begin
            if (hit) begin
              state_q <= ACK;
              avec_q  <= 1'b1;
            end else begin
              state_q <= SPUR;
`ifdef IRQ_CONTROLLER_SPURIOUS_BERR_EN
              berr_q  <= 1'b1;
`else
              avec_q  <= 1'b1;
`endif
            end
          end else begin
            ipl_q <= prio_enc(active);
          end
        end
        ACK, SPUR: begin
          if (!AS_IN) begin
            state_q <= IDLE;
            avec_q  <= 1'b0;
`ifdef IRQ_CONTROLLER_SPURIOUS_BERR_EN
            berr_q  <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IPL     = ipl_q;
  assign AVEC    = avec_q;
  assign PENDING = pend_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  irq;
  logic        as_s;
  logic [2:0]  fc;
  logic [23:0] addr;
  logic        mwr;
  logic [6:0]  mdata;
  logic [2:0]  ipl;
  logic        avec;
  logic        berr;
  logic [6:0]  pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_controller dut (
    .CPUCLK_IN    (clk),
    .RESET_n_IN   (rst_n),
    .IRQ_IN       (irq),
    .AS_IN        (as_s),
    .FC_IN        (fc),
    .ADDR_IN      (addr),
    .MASK_WR_IN   (mwr),
    .MASK_DATA_IN (mdata),
    .IPL          (ipl),
    .AVEC         (avec),
    .BERR         (berr),
    .PENDING      (pending)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_mask(input logic [6:0] m);
    mwr = 1'b1; mdata = m;
    step(1);
    mwr = 1'b0;
  endtask

  task automatic iack_start(input logic [2:0] l);
    as_s = 1'b1; fc = 3'b111; addr = {4'h0, 4'hF, 12'h000, l, 1'b0};
  endtask

  initial begin
    rst_n = 1'b0; irq = 7'd0; as_s = 1'b0; fc = 3'd0; addr = 24'd0;
    mwr = 1'b0; mdata = 7'd0;
    step(2);
    chk("rst_ipl", {5'd0, ipl}, 8'd0);
    chk("rst_avec", {7'd0, avec}, 8'd0);
    chk("rst_berr", {7'd0, berr}, 8'd0);
    chk("rst_pend", {1'b0, pending}, 8'd0);
    rst_n = 1'b1;
    step(1);

    // level 3, level-mode
    write_mask(7'h7F);
    irq = 7'b0000100;
    step(3);
    chk("l3_pend", {1'b0, pending}, 8'h04);
    chk("l3_ipl_early", {5'd0, ipl}, 8'd0);
    step(1);
    chk("l3_ipl", {5'd0, ipl}, 8'd3);
    chk("l3_avec", {7'd0, avec}, 8'd0);

    // levels 2 and 5 together, then drop 5
    irq = 7'b0010010;
    step(4);
    chk("l25_pend", {1'b0, pending}, 8'h12);
    chk("l25_ipl", {5'd0, ipl}, 8'd5);
    irq = 7'b0000010;
    step(3);
    chk("l2_pend", {1'b0, pending}, 8'h02);
    chk("l2_ipl_hold", {5'd0, ipl}, 8'd5);
    step(1);
    chk("l2_ipl", {5'd0, ipl}, 8'd2);
    irq = 7'd0;
    step(4);
    chk("none_ipl", {5'd0, ipl}, 8'd0);

    // non-IACK bus cycle and level-0 IACK are ignored
    as_s = 1'b1; fc = 3'b101; addr = 24'h0F000E;
    step(2);
    chk("nonack_avec", {7'd0, avec}, 8'd0);
    iack_start(3'd0);
    step(2);
    chk("l0_avec", {7'd0, avec}, 8'd0);
    as_s = 1'b0;
    step(1);

    // edge level 7 with mask 0 is non-maskable
    write_mask(7'h00);
    irq = 7'h40;
    step(1);
    irq = 7'h00;
    step(2);
    chk("l7_pend", {1'b0, pending}, 8'h40);
    step(1);
    chk("l7_ipl", {5'd0, ipl}, 8'd7);
    iack_start(3'd7);
    step(1);
    chk("l7_avec", {7'd0, avec}, 8'd1);
    chk("l7_clr", {1'b0, pending}, 8'h00);
    chk("l7_ipl_frz", {5'd0, ipl}, 8'd7);
    step(2);
    chk("l7_avec_hold", {7'd0, avec}, 8'd1);
    as_s = 1'b0;
    step(1);
    chk("l7_avec_drop", {7'd0, avec}, 8'd0);
    chk("l7_ipl_still", {5'd0, ipl}, 8'd7);
    step(1);
    chk("l7_ipl_zero", {5'd0, ipl}, 8'd0);

    // rise coincides with acknowledge clear: set wins
    irq = 7'h40;
    step(1);
    irq = 7'h00;
    step(3);
    chk("sw_pend0", {1'b0, pending}, 8'h40);
    irq = 7'h40;
    step(1);
    irq = 7'h00;
    step(1);
    iack_start(3'd7);
    step(1);
    chk("sw_avec", {7'd0, avec}, 8'd1);
    chk("sw_pend", {1'b0, pending}, 8'h40);
    as_s = 1'b0;
    step(1);
    chk("sw_avec_drop", {7'd0, avec}, 8'd0);
    iack_start(3'd7);
    step(1);
    chk("sw2_avec", {7'd0, avec}, 8'd1);
    chk("sw2_pend", {1'b0, pending}, 8'h00);
    as_s = 1'b0;
    step(1);
    chk("sw2_avec_drop", {7'd0, avec}, 8'd0);

    // spurious IACK for level 4
    iack_start(3'd4);
    step(2);
`ifdef IRQ_CONTROLLER_SPURIOUS_BERR_EN
    chk("spur_berr", {7'd0, berr}, 8'd1);
    chk("spur_avec", {7'd0, avec}, 8'd0);
`else
    chk("spur_berr", {7'd0, berr}, 8'd0);
    chk("spur_avec", {7'd0, avec}, 8'd1);
`endif
    chk("spur_pend", {1'b0, pending}, 8'h00);
    as_s = 1'b0;
    step(1);
    chk("spur_end_avec", {7'd0, avec}, 8'd0);
    chk("spur_end_berr", {7'd0, berr}, 8'd0);

    // async reset while in ACK
    write_mask(7'h7F);
    irq = 7'h44;
    step(1);
    irq = 7'h04;
    step(3);
    chk("ra_ipl", {5'd0, ipl}, 8'd7);
    iack_start(3'd7);
    step(1);
    chk("ra_avec", {7'd0, avec}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_avec_rst", {7'd0, avec}, 8'd0);
    chk("ra_ipl_rst", {5'd0, ipl}, 8'd0);
    chk("ra_pend_rst", {1'b0, pending}, 8'h00);
    as_s = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(5);
    chk("ra_pend_after", {1'b0, pending}, 8'h04);
    chk("ra_mask_reset", {5'd0, ipl}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
